// File: rtl/fb_pkg.sv
// Shared constants and types for the scanout-side frame buffer reader.
//   LINE_PIXELS  : 16-bit words per display line
//   NUM_LINES    : lines per frame
//   ADDR_W       : SRAM word-address width
//   FRAME_OFFSET : word offset of the odd-frame half
//   READ_LAT     : cycles from address/OE_N issue to valid read data
package fb_pkg;

  localparam int unsigned LINE_PIXELS = 640;
  localparam int unsigned NUM_LINES   = 480;
  localparam int unsigned ADDR_W      = 20;
  localparam int unsigned READ_LAT    = 2;
  localparam int unsigned PIX_W       = 16;
  localparam int unsigned IDX_W       = 10;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] sram_addr_t;

  localparam sram_addr_t FRAME_OFFSET = sram_addr_t'(LINE_PIXELS * NUM_LINES);

  typedef enum logic [1:0] {IDLE, REQ, READ, DRAIN} fbr_state_t;

  // Word offset of a line within a frame half, truncated to the address width.
  function automatic sram_addr_t line_offset(input logic [IDX_W-1:0] line);
    return sram_addr_t'(line) * sram_addr_t'(LINE_PIXELS);
  endfunction

endpackage

// File: rtl/frame_buffer_line_buffer.sv
// Ping-pong line buffer: two banks of Depth words. One write port into the
// bank chosen by wr_bank_i, one registered read port from rd_bank_i.
// Reads beyond Depth return zero.
//   clk_i, rst_i           : clock, synchronous active-high reset (read register)
//   wr_en_i, wr_bank_i     : write strobe and target bank
//   wr_addr_i, wr_data_i   : write word index and data
//   rd_bank_i, rd_addr_i   : read bank and word index
//   rd_data_o              : read data, one cycle after rd_addr_i
module line_buffer
  import fb_pkg::*;
#(
  parameter int unsigned Depth = LINE_PIXELS,
  parameter int unsigned Width = PIX_W,
  parameter int unsigned IdxW  = IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [IdxW-1:0]  wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_bank_i,
  input  logic [IdxW-1:0]  rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem [2][Depth];
  logic [Width-1:0] rd_data_q;

  logic wr_in_range, rd_in_range;
  assign wr_in_range = 32'(wr_addr_i) < Depth;
  assign rd_in_range = 32'(rd_addr_i) < Depth;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_in_range) begin
      mem[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_in_range) begin
      rd_data_q <= mem[rd_bank_i][rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_buffer_reader.sv
// Scanout-side reader for the SRAM double frame buffer. On each line_req it
// swaps the ping-pong line buffer and prefetches one display line from the
// completed frame half into the fill bank, sharing the SRAM with the frame
// writer via rd_req/rd_grant. The VGA path reads pixels from the display bank.
//   Clk, Reset          : clock, synchronous active-high reset
//   even_frame          : 1 = writer on odd half, read the even half
//   frame_start         : vsync pulse, latches the read base
//   line_req, line_num  : fetch request pulse and line index
//   rd_req, rd_grant    : SRAM bus request / grant
//   SRAM_ADDRESS        : read address
//   SRAM_OE_N           : active-low output enable
//   Data_from_SRAM      : read data, READ_LAT cycles after issue
//   pix_x, pix_data     : display-side read, one-cycle latency
//   fetch_busy          : fetch in progress
//   underrun, overrun   : sticky error flags
module frame_buffer_reader
  import fb_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             even_frame,
  input  logic             frame_start,
  input  logic             line_req,
  input  logic [IDX_W-1:0] line_num,
  output logic             rd_req,
  input  logic             rd_grant,
  output sram_addr_t       SRAM_ADDRESS,
  output logic             SRAM_OE_N,
  input  pixel_t           Data_from_SRAM,
  input  logic [IDX_W-1:0] pix_x,
  output pixel_t           pix_data,
  output logic             fetch_busy,
  output logic             underrun,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LinePix = IDX_W'(LINE_PIXELS);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LINE_PIXELS - 1);

  fbr_state_t          state_q, state_d;
  sram_addr_t          base_q, base_d;
  sram_addr_t          line_addr_q, line_addr_d;
  logic [IDX_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic                disp_sel_q, disp_sel_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;

  sram_addr_t base_eff;
  logic       issue;
  logic       capture;

  // A coincident frame_start must already steer the fetch it arrives with.
  assign base_eff = frame_start ? (even_frame ? '0 : FRAME_OFFSET) : base_q;
  assign capture  = vld_q[READ_LAT-1];

  always_comb begin
    state_d     = state_q;
    base_d      = base_eff;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    disp_sel_d  = disp_sel_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    rd_req      = 1'b0;
    SRAM_OE_N   = 1'b1;
    issue       = 1'b0;

    if (capture) begin
      wr_cnt_d = wr_cnt_q + IDX_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (line_req) begin
          disp_sel_d = ~disp_sel_q;
          // The bank being exposed for display never finished filling.
          if (wr_cnt_q < LinePix) begin
            underrun_d = 1'b1;
          end
          line_addr_d = base_eff + line_offset(line_num);
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        rd_req = 1'b1;
        if (rd_grant) begin
          state_d = READ;
        end
      end
      READ: begin
        rd_req = 1'b1;
        if (rd_grant && (issue_cnt_q < LinePix)) begin
          issue       = 1'b1;
          SRAM_OE_N   = 1'b0;
          issue_cnt_d = issue_cnt_q + IDX_W'(1);
          if (issue_cnt_q == LastIdx) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (vld_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (line_req && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // Valid bits track each issued read through the SRAM latency.
    vld_d    = vld_q << 1;
    vld_d[0] = issue;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      vld_q       <= '0;
      disp_sel_q  <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      vld_q       <= vld_d;
      disp_sel_q  <= disp_sel_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign SRAM_ADDRESS = line_addr_q + sram_addr_t'(issue_cnt_q);
  assign fetch_busy   = state_q != IDLE;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;

  logic wr_en, wr_bank;
  assign wr_en   = capture && !Reset;
  assign wr_bank = ~disp_sel_q;

  line_buffer #(
    .Depth(LINE_PIXELS),
    .Width(PIX_W),
    .IdxW (IDX_W)
  ) u_line_buffer (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .wr_en_i  (wr_en),
    .wr_bank_i(wr_bank),
    .wr_addr_i(wr_cnt_q),
    .wr_data_i(Data_from_SRAM),
    .rd_bank_i(disp_sel_q),
    .rd_addr_i(pix_x),
    .rd_data_o(pix_data)
  );

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Self-checking bench for frame_buffer_reader: SRAM model with two-cycle read
// latency, table-driven fetch vectors, randomized grant/line fetches and
// hand-written reset / overrun / no-grant sequences.
module tb_frame_buffer_reader;
  import fb_pkg::*;

  logic       clk;
  logic       Reset, even_frame, frame_start, line_req, rd_grant;
  logic [9:0] line_num, pix_x;
  logic       rd_req, SRAM_OE_N, fetch_busy, underrun, overrun;
  sram_addr_t SRAM_ADDRESS;
  pixel_t     Data_from_SRAM, pix_data;

  int checks = 0;
  int errors = 0;

  frame_buffer_reader dut (
    .Clk           (clk),
    .Reset         (Reset),
    .even_frame    (even_frame),
    .frame_start   (frame_start),
    .line_req      (line_req),
    .line_num      (line_num),
    .rd_req        (rd_req),
    .rd_grant      (rd_grant),
    .SRAM_ADDRESS  (SRAM_ADDRESS),
    .SRAM_OE_N     (SRAM_OE_N),
    .Data_from_SRAM(Data_from_SRAM),
    .pix_x         (pix_x),
    .pix_data      (pix_data),
    .fetch_busy    (fetch_busy),
    .underrun      (underrun),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: contents are a fixed function of the address.
  function automatic pixel_t sram_word(input sram_addr_t a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  sram_addr_t issued[$];
  int         gnt_viol = 0;
  sram_addr_t h1_a, h2_a;
  logic       h1_v, h2_v;

  always @(posedge clk) begin
    h2_a <= h1_a;
    h2_v <= h1_v;
    h1_a <= SRAM_ADDRESS;
    h1_v <= !SRAM_OE_N;
    if (SRAM_OE_N === 1'b0) begin
      issued.push_back(SRAM_ADDRESS);
      if (rd_grant !== 1'b1) gnt_viol <= gnt_viol + 1;
    end
  end

  assign Data_from_SRAM = (h2_v === 1'b1) ? sram_word(h2_a) : 16'hDEAD;

  // Reference model: which line each buffer holds and whether it is complete.
  sram_addr_t m_base;
  sram_addr_t fill_base, disp_base;
  bit         fill_complete, disp_valid, m_underrun, m_overrun;

  function automatic void model_reset();
    m_base        = '0;
    fill_complete = 1'b0;
    disp_valid    = 1'b0;
    m_underrun    = 1'b0;
    m_overrun     = 1'b0;
  endfunction

  function automatic void model_line_req(input sram_addr_t first);
    disp_valid = fill_complete;
    disp_base  = fill_base;
    if (!fill_complete) m_underrun = 1'b1;
    fill_base     = first;
    fill_complete = 1'b0;
  endfunction

  function automatic sram_addr_t calc_first(input int fs, input bit ev, input int line);
    int unsigned b;
    b = (fs == 0) ? int'(m_base) : (ev ? 0 : LINE_PIXELS * NUM_LINES);
    return sram_addr_t'(b + line * LINE_PIXELS);
  endfunction

  function automatic bit exp_pix(input logic [9:0] x, output pixel_t v);
    v = '0;
    if (int'(x) >= LINE_PIXELS) return 1'b1;
    if (!disp_valid) return 1'b0;
    v = sram_word(disp_base + sram_addr_t'(x));
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fs: 0 = no frame_start, 1 = frame_start the cycle before, 2 = coincident.
  task automatic do_fetch(input bit ev, input int fs, input int line, input int gap_at,
                          input int gap_len, input bit rnd, input int ovr_at,
                          input sram_addr_t exp_first, input sram_addr_t exp_last,
                          input int exp_cycles);
    int start, viol0, cyc, gap_left, n_iss, ord_err;
    bit gap_done, done;
    pixel_t ep;
    even_frame = ev;
    if (fs == 1) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    if (fs != 0) m_base = ev ? '0 : FRAME_OFFSET;
    if (fs == 2) frame_start = 1'b1;
    line_num = 10'(line);
    line_req = 1'b1;
    rd_grant = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start    = issued.size();
    viol0    = gnt_viol;
    tick();
    line_req    = 1'b0;
    frame_start = 1'b0;
    model_line_req(exp_first);
    check("busy_after_req", fetch_busy, 1);
    check("underrun_at_req", underrun, m_underrun);

    cyc = 0; done = 0; gap_done = 0; gap_left = 0;
    while (!done && cyc < 4000) begin
      n_iss = issued.size() - start;
      if (!gap_done && gap_len > 0 && n_iss == gap_at) begin
        gap_done = 1;
        gap_left = gap_len;
      end
      if (gap_left > 0) begin
        rd_grant = 1'b0;
        gap_left--;
      end else if (rnd) begin
        rd_grant = ($urandom_range(0, 3) != 0);
      end else begin
        rd_grant = 1'b1;
      end
      line_req = (ovr_at > 0 && cyc == ovr_at);
      if (line_req) m_overrun = 1'b1;
      case (cyc)
        0:       pix_x = 10'd5;
        1:       pix_x = 10'd639;
        2:       pix_x = 10'd640;
        3:       pix_x = 10'd1023;
        default: pix_x = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(640, 1023))
                                                       : 10'($urandom_range(0, 639));
      endcase
      tick();
      cyc++;
      line_req = 1'b0;
      if (exp_pix(pix_x, ep)) check("pix_data", pix_data, ep);
      done = !fetch_busy;
    end

    check("fetch_done", done, 1);
    if (exp_cycles > 0) check("fetch_cycles", cyc, exp_cycles);
    n_iss = issued.size() - start;
    check("issue_count", n_iss, LINE_PIXELS);
    if (n_iss > 0) begin
      check("first_addr", issued[start], exp_first);
      check("last_addr", issued[start+n_iss-1], exp_last);
    end
    ord_err = 0;
    for (int i = 0; i < n_iss; i++) begin
      if (issued[start+i] !== sram_addr_t'(exp_first + sram_addr_t'(i))) ord_err++;
    end
    check("addr_order_errs", ord_err, 0);
    check("issue_without_grant", gnt_viol - viol0, 0);
    check("underrun_end", underrun, m_underrun);
    check("overrun_end", overrun, m_overrun);
    check("rd_req_idle", rd_req, 0);
    if (done) fill_complete = 1'b1;
  endtask

  typedef struct {
    bit         ev;
    int         fs;
    int         line;
    int         gap_at;
    int         gap_len;
    int         ovr_at;
    sram_addr_t first;
    sram_addr_t last;
    int         cycles;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    int         n0, n1, ln, fs;
    bit         ev;
    sram_addr_t f;

    vecs[0] = '{1'b1, 1, 0,   0,   0,  0,   20'h00000, 20'h0027F, 644};
    vecs[1] = '{1'b0, 1, 2,   0,   0,  0,   20'h4B500, 20'h4B77F, 644};
    vecs[2] = '{1'b0, 0, 100, 100, 10, 0,   20'h5AA00, 20'h5AC7F, 654};
    vecs[3] = '{1'b1, 2, 479, 0,   0,  0,   20'h4AD80, 20'h4AFFF, 644};
    vecs[4] = '{1'b0, 2, 479, 0,   0,  0,   20'h95D80, 20'h95FFF, 644};
    vecs[5] = '{1'b1, 1, 1,   0,   0,  300, 20'h00280, 20'h004FF, 644};

    Reset = 1'b1; even_frame = 1'b0; frame_start = 1'b0; line_req = 1'b0;
    rd_grant = 1'b0; line_num = '0; pix_x = '0;
    fill_base = '0; disp_base = '0;
    model_reset();
    repeat (3) tick();
    check("rst_rd_req", rd_req, 0);
    check("rst_oe_n", SRAM_OE_N, 1);
    check("rst_addr", SRAM_ADDRESS, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    Reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      do_fetch(vecs[v].ev, vecs[v].fs, vecs[v].line, vecs[v].gap_at, vecs[v].gap_len,
               1'b0, vecs[v].ovr_at, vecs[v].first, vecs[v].last, vecs[v].cycles);
      repeat ($urandom_range(0, 3)) tick();
    end

    for (int r = 0; r < 4; r++) begin
      ev = 1'($urandom_range(0, 1));
      fs = $urandom_range(0, 2);
      ln = $urandom_range(0, NUM_LINES - 1);
      f  = calc_first(fs, ev, ln);
      do_fetch(ev, fs, ln, 0, 0, 1'b1, 0, f, f + 20'd639, 0);
    end

    // Reset in the middle of a burst.
    even_frame = 1'b1; frame_start = 1'b1; line_num = 10'd3; line_req = 1'b1;
    rd_grant = 1'b1;
    tick();
    frame_start = 1'b0; line_req = 1'b0;
    repeat (50) tick();
    check("busy_mid_read", fetch_busy, 1);
    check("oe_mid_read", SRAM_OE_N, 0);
    Reset = 1'b1;
    tick();
    check("rstmid_rd_req", rd_req, 0);
    check("rstmid_oe_n", SRAM_OE_N, 1);
    check("rstmid_busy", fetch_busy, 0);
    check("rstmid_underrun", underrun, 0);
    check("rstmid_overrun", overrun, 0);
    check("rstmid_pix_data", pix_data, 0);
    Reset = 1'b0;
    model_reset();
    n1 = issued.size();
    repeat (5) tick();
    check("no_issue_after_reset", issued.size() - n1, 0);

    // No grant ever: fetch stays pending, the swap still flags underrun.
    rd_grant = 1'b0; line_num = 10'd7; line_req = 1'b1;
    tick();
    line_req = 1'b0;
    model_line_req(calc_first(0, 1'b0, 7));
    check("nogrant_underrun", underrun, m_underrun);
    n0 = issued.size();
    repeat (200) tick();
    check("nogrant_busy", fetch_busy, 1);
    check("nogrant_rd_req", rd_req, 1);
    check("nogrant_oe_n", SRAM_OE_N, 1);
    check("nogrant_no_issue", issued.size() - n0, 0);
    check("nogrant_overrun_before", overrun, 0);
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
    m_overrun = 1'b1;
    check("nogrant_overrun", overrun, m_overrun);
    check("nogrant_underrun_hold", underrun, m_underrun);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_reset();
    check("rst2_underrun", underrun, 0);
    check("rst2_overrun", overrun, 0);
    tick();

    // After reset the base is 0 even though even_frame selects the odd half.
    do_fetch(1'b0, 0, 5, 0, 0, 1'b0, 0, 20'h00C80, 20'h00EFF, 644);
    ev = 1'($urandom_range(0, 1));
    ln = $urandom_range(0, NUM_LINES - 1);
    f  = calc_first(1, ev, ln);
    do_fetch(ev, 1, ln, 0, 0, 1'b0, 0, f, f + 20'd639, 644);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_reader.md
Name: frame_buffer_reader

Overview:
- Scanout-side reader for the SRAM double frame buffer. The frame writer fills one half per step; this block reads the other, completed half.
- Prefetches one display line at a time from SRAM into a ping-pong line buffer. The VGA colour path reads pixels out of that buffer.
- Shares the SRAM with the frame writer through a request/grant handshake. Drives only address and OE_N; the write path and tristate stay external.

Parameters:
- LINE_PIXELS, 640, pixels (16-bit words) per line
- NUM_LINES, 480, lines per frame
- ADDR_W, 20, SRAM address width
- FRAME_OFFSET, 20'h4B000, word offset of the odd-frame half (LINE_PIXELS*NUM_LINES)
- READ_LAT, 2, cycles from address/OE_N-low issue to valid read data (includes the external OE sync register)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- even_frame  in  1  frame writer's current target; 1 = writer on odd half, so read the even half (base 0)
- frame_start  in  1  one-cycle pulse at vertical sync; latches the read base
- line_req  in  1  one-cycle pulse: fetch line line_num, swap buffers
- line_num  in  10  line to fetch, 0..NUM_LINES-1
- rd_req  out  1  SRAM bus request to the arbiter
- rd_grant  in  1  bus granted; holds while asserted
- SRAM_ADDRESS  out  ADDR_W  read address
- SRAM_OE_N  out  1  active-low output enable
- Data_from_SRAM  in  16  read data
- pix_x  in  10  display-side pixel index
- pix_data  out  16  pixel at pix_x from the display buffer, 1-cycle latency
- fetch_busy  out  1  line fetch in progress
- underrun  out  1  sticky: swap occurred before the fill completed
- overrun  out  1  sticky: line_req while fetch_busy

Behaviour:
- Reset values:
  - rd_req=0, SRAM_OE_N=1, SRAM_ADDRESS=0, pix_data=0.
  - fetch_busy=0, underrun=0, overrun=0.
  - Read base=0; display buffer index=0; state IDLE.
- Read base: on frame_start, base <= even_frame ? 0 : FRAME_OFFSET. If frame_start and line_req coincide, the new base applies to that fetch.
- line_req in IDLE:
  - Swap fill/display buffers.
  - If the last fill was incomplete (fill count < LINE_PIXELS), set underrun.
  - Line address <= base + line_num*LINE_PIXELS, truncated to ADDR_W.
  - Issue count and write count <= 0. Go to REQ.
- line_req while not IDLE: set overrun, ignore the request, no swap, current fetch continues.
- line_num >= NUM_LINES: treated as a valid fetch (no clamping); the bench shall not rely on it.
- States:
  - IDLE: rd_req=0, OE_N=1.
  - REQ: rd_req=1; on rd_grant go to READ.
  - READ: each cycle with rd_grant=1 and issue count < LINE_PIXELS:
    - SRAM_ADDRESS = line address + issue count, OE_N=0.
    - Push a valid bit into a READ_LAT-deep shift register; issue count++.
  - READ, grant dropped mid-burst: OE_N=1, stop issuing, keep rd_req=1; in-flight data still drains. Resume at the next unissued address when grant returns.
  - READ, last address issued: go to DRAIN with OE_N=1 and rd_req=0.
  - DRAIN: wait until the valid pipeline is empty, then IDLE.
- Data capture: when the valid bit exits the pipeline, write Data_from_SRAM to fill buffer[write count]; write count++.
- fetch_busy = state != IDLE.
- Full-grant fetch: LINE_PIXELS + READ_LAT + 2 cycles from line_req to IDLE.
- Display read: pix_data <= display buffer[pix_x] each cycle; pix_x >= LINE_PIXELS returns 0.
- Buffer storage: inferred dual-port RAM, 2 x LINE_PIXELS x 16.
- Sticky flags clear only on Reset.
- Reset mid-fetch: returns to IDLE next cycle, OE_N=1, rd_req=0; in-flight data is discarded.

Decomposition:
- Package fb_pkg:
  - LINE_PIXELS, NUM_LINES, FRAME_OFFSET, ADDR_W.
  - Typedef pixel_t (16-bit), sram_addr_t.
  - Enum fbr_state_t {IDLE, REQ, READ, DRAIN}.
- Sub-module line_buffer: ping-pong dual-port RAM with a bank-select input, one write port and one registered read port.

Test Plan:
- Grant held at 1, even_frame=1, frame_start then line_req with line_num=0:
  - Addresses 0..639 issued consecutively.
  - After the next swap, pix_x=5 gives the SRAM word at address 5.
  - fetch_busy low after 644 cycles.
- frame_start with even_frame=0, line_req with line_num=2: first address 0x4B000+1280=0x4B500, last 0x4B77F.
- Grant dropped for 10 cycles after 100 issues: no address issued during the gap; resumes at line address + 100; all 640 words stored in order, no duplicates.
- line_req again at cycle 300 of a fetch: overrun=1, no swap, fetch completes normally.
- Grant never given, second line_req after the first fetch times out: underrun=1; buffers still swap.
- Reset asserted mid-READ: next cycle rd_req=0, OE_N=1, fetch_busy=0, flags=0; a new line_req fetches normally.
